// File: rtl/window_accum.sv
// ============================================================================
// Module      : window_accum
// Description : Sums 2^WIN_LOG2 signed 9-bit samples per window and presents
//               the sum and average with a valid/ready handshake.
//               Define WINDOW_ACCUM_ROUND_EN for round-half-up averaging
//               (floor truncation otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_accum #(
    parameter int WIN_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [8:0]            in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8+WIN_LOG2:0]   out_sum,
    output logic [8:0]            out_avg
);

    localparam int c_SW = 9 + WIN_LOG2;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic signed [c_SW-1:0]     r_acc;
    logic [WIN_LOG2-1:0]        r_cnt;
    logic                       w_accept;
    logic                       w_last;
    logic signed [c_SW-1:0]     w_sum_nxt;
    logic [8:0]                 w_avg;

    assign w_accept  = (r_state == ACC) && in_valid && !flush;
    assign w_last    = w_accept && (r_cnt == {WIN_LOG2{1'b1}});
    assign w_sum_nxt = r_acc + {{WIN_LOG2{in_data[8]}}, in_data};

`ifdef WINDOW_ACCUM_ROUND_EN
    // One extra bit of headroom so adding the half-LSB can never wrap.
    localparam logic signed [c_SW:0] c_HALF = (c_SW+1)'(1) << (WIN_LOG2 - 1);
    logic signed [c_SW:0] w_round;
    assign w_round = {w_sum_nxt[c_SW-1], w_sum_nxt} + c_HALF;
    assign w_avg   = 9'(w_round >>> WIN_LOG2);
`else
    assign w_avg   = 9'(w_sum_nxt >>> WIN_LOG2);
`endif

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_last)    w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator is cleared on completion so HOLD exits straight into a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            out_sum <= '0;
            out_avg <= '0;
        end else if (r_state == ACC) begin
            if (flush) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    out_sum <= w_sum_nxt;
                    out_avg <= w_avg;
                end else begin
                    r_acc   <= w_sum_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
